// File: rtl/if_prefetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit_pkg
// Shared constants for the instruction-fetch front end.
//   DEF_RESET_PC : default fetch PC after reset
//   WORD_BYTES   : instruction word size in bytes (PC increment)
//   NOP_INSN     : encoding presented for empty/flushed slots
//   ptr_w()      : pointer width for a queue of a given depth
// ---------------------------------------------------------------------------
package if_prefetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES   = 32'd4;
    localparam logic [31:0] NOP_INSN     = 32'h0000_0000;

    // Queue pointer width; a depth of 2 still needs a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// if_prefetch_fifo
// In-order circular queue holding {pc, instruction} pairs for the fetch unit.
// Ports:
//   clk          : clock
//   rst          : asynchronous active-low reset
//   i_push       : enqueue i_push_data
//   i_push_data  : entry to enqueue
//   i_pop        : dequeue the head entry (ignored when empty)
//   i_flush      : empty the queue; overrides push and pop
//   o_count      : number of valid entries (0..DEPTH)
//   o_valid      : queue holds at least one entry
//   o_head       : head entry, zero when empty
// ---------------------------------------------------------------------------
module if_prefetch_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [ptr_w(DEPTH):0]    o_count,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_head
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only observed through o_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

    // The requester reserves a slot before issuing, so a push into a full
    // queue without a simultaneous pop indicates a broken space check.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && !w_pop && (r_count == (PW+1)'(DEPTH))));

endmodule

// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
// Instruction-fetch front end feeding the IF/ID register. Owns the fetch PC,
// issues one word read at a time to a variable-latency memory and buffers
// returned words, tagged with their PC, in an in-order queue. Redirects
// flush the queue and retarget the fetch PC; a read in flight at redirect
// time is dropped when it returns.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   redirect         : flush and refetch from redirect_pc
//   redirect_pc      : new target, low two bits forced to zero
//   inst_ready       : IF/ID accepts the head entry
//   inst_valid       : head entry valid
//   inst, inst_pc    : head instruction and its PC
//   inst_pcplus4     : inst_pc + 4
//   imem_req/addr    : read request and word address
//   imem_gnt         : request accepted this cycle
//   imem_rvalid/rdata: read response
// ---------------------------------------------------------------------------
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pcplus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int PW = ptr_w(DEPTH);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_outstanding;
    logic        r_drop;

    logic [PW:0] w_count;
    logic [PW:0] w_inflight;
    logic [63:0] w_head;
    logic        w_head_valid;
    logic        w_rvalid;
    logic        w_blocked;
    logic        w_space;
    logic        w_grant;
    logic        w_push;
    logic        w_pop;

    // A response with nothing outstanding (e.g. one issued before a reset)
    // belongs to no request of ours and is ignored.
    assign w_rvalid   = imem_rvalid && r_outstanding;
    assign w_blocked  = r_outstanding && !imem_rvalid;
    // The in-flight read already owns a queue slot.
    assign w_inflight = w_count + (PW+1)'(r_outstanding);
    assign w_space    = (w_inflight < (PW+1)'(DEPTH));

    // Gated by rst so the request drops immediately on async reset.
    assign imem_req  = rst && !w_blocked && w_space && !redirect;
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req && imem_gnt;

    assign w_push = w_rvalid && !r_drop && !redirect;
    assign w_pop  = w_head_valid && inst_ready && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            if (redirect) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                // A read still in flight returns stale data later.
                r_drop     <= w_blocked;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + WORD_BYTES;
                    r_req_pc   <= r_fetch_pc;
                end
                if (w_rvalid) r_drop <= 1'b0;
            end

            if (w_grant)       r_outstanding <= 1'b1;
            else if (w_rvalid) r_outstanding <= 1'b0;
        end
    end

    if_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_req_pc, imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_count     (w_count),
        .o_valid     (w_head_valid),
        .o_head      (w_head)
    );

    assign inst_valid   = w_head_valid;
    assign inst         = w_head_valid ? w_head[31:0] : NOP_INSN;
    assign inst_pc      = w_head[63:32];
    assign inst_pcplus4 = w_head_valid ? (w_head[63:32] + WORD_BYTES) : 32'h0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
module tb_if_prefetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pcplus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        mem_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    // second instance: wrap-around reset PC, always-granting 1-cycle memory
    logic        inst_valid2;
    logic [31:0] inst2, inst_pc2, inst_pcplus4_2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        m_rvalid2;
    logic [31:0] m_rdata2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_ready(inst_ready), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_pcplus4(inst_pcplus4), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(mem_gnt), .imem_rvalid(m_rvalid),
        .imem_rdata(m_rdata)
    );

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(32'h0),
        .inst_ready(1'b1), .inst_valid(inst_valid2), .inst(inst2),
        .inst_pc(inst_pc2), .inst_pcplus4(inst_pcplus4_2), .imem_req(imem_req2),
        .imem_addr(imem_addr2), .imem_gnt(1'b1), .imem_rvalid(m_rvalid2),
        .imem_rdata(m_rdata2)
    );

    // Memory models: grants sampled on the falling edge, responses driven
    // 1 time unit after the rising edge, in order, lat cycles after grant.
    typedef struct { logic [31:0] a; int due; } rd_t;
    rd_t         mq[$];
    int          cyc_n = 0;
    int          lat   = 1;
    logic        g2;
    logic [31:0] a2;

    initial begin
        m_rvalid = 1'b0; m_rdata = 32'h0;
        m_rvalid2 = 1'b0; m_rdata2 = 32'h0;
        g2 = 1'b0; a2 = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req && mem_gnt) mq.push_back('{imem_addr, cyc_n + lat});
            g2 = imem_req2;
            a2 = imem_addr2;
            @(posedge clk);
            #1;
            cyc_n++;
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
            if (mq.size() > 0 && mq[0].due <= cyc_n) begin
                m_rvalid = 1'b1;
                m_rdata  = mq[0].a ^ KEY;
                void'(mq.pop_front());
            end
            m_rvalid2 = g2;
            m_rdata2  = g2 ? (a2 ^ KEY) : 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Hold reset for several cycles, release mid-cycle; returns at the
    // sample point of the first cycle out of reset (cycle 0).
    task automatic do_reset(input logic rdy, input int l);
        nxt();
        rst = 1'b0;
        inst_ready = rdy;
        redirect = 1'b0;
        lat = l;
        repeat (4) nxt();
        rst = 1'b1;
        smp();
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        inst_ready = 1'b1; mem_gnt = 1'b1; lat = 1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        smp();
        check("rst_valid", inst_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_pcp4", inst_pcplus4, 32'h0);
        check("rst_req2", imem_req2, 0);

        // ---- streaming, latency 1 (both instances) ----
        nxt(); rst = 1'b1; smp();
        check("t1_req_c0", imem_req, 1);
        check("t1_addr_c0", imem_addr, 32'h0);
        check("t1_valid_c0", inst_valid, 0);
        check("wr_addr_c0", imem_addr2, 32'hFFFF_FFF8);
        nxt(); smp();
        check("t1_addr_c1", imem_addr, 32'h4);
        check("t1_valid_c1", inst_valid, 0);
        check("wr_addr_c1", imem_addr2, 32'hFFFF_FFFC);
        nxt(); smp();
        check("t1_addr_c2", imem_addr, 32'h8);
        check("t1_valid_c2", inst_valid, 1);
        check("t1_pc_c2", inst_pc, 32'h0);
        check("t1_inst_c2", inst, 32'hDEAD_0000);
        check("wr_addr_c2", imem_addr2, 32'h0);
        check("wr_pc_c2", inst_pc2, 32'hFFFF_FFF8);
        check("wr_pcp4_c2", inst_pcplus4_2, 32'hFFFF_FFFC);
        nxt(); smp();
        check("t1_pc_c3", inst_pc, 32'h4);
        check("t1_pcp4_c3", inst_pcplus4, 32'h8);
        check("t1_inst_c3", inst, 32'hDEAD_0004);
        check("wr_pc_c3", inst_pc2, 32'hFFFF_FFFC);
        check("wr_pcp4_c3", inst_pcplus4_2, 32'h0);

        // ---- backpressure: 10 cycles of inst_ready=0 ----
        do_reset(1'b0, 1);
        check("t2_addr_c0", imem_addr, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            nxt(); smp();
            if (c >= 5) check("t2_req_full", imem_req, 0);
        end
        check("t2_valid_full", inst_valid, 1);
        check("t2_head_full", inst_pc, 32'h0);
        nxt(); inst_ready = 1'b1; smp();
        check("t2_pc_d0", inst_pc, 32'h0);
        check("t2_req_d0", imem_req, 0);
        nxt(); smp();
        check("t2_pc_d1", inst_pc, 32'h4);
        check("t2_req_d1", imem_req, 1);
        check("t2_addr_d1", imem_addr, 32'h10);
        nxt(); smp();
        check("t2_pc_d2", inst_pc, 32'h8);
        nxt(); smp();
        check("t2_pc_d3", inst_pc, 32'hC);
        nxt(); smp();
        check("t2_pc_d4", inst_pc, 32'h10);
        check("t2_inst_d4", inst, 32'hDEAD_0010);

        // ---- redirect with a read in flight, latency 3 ----
        do_reset(1'b1, 3);
        for (int c = 1; c <= 6; c++) begin
            nxt(); smp();
        end
        check("t3_req_8", imem_req, 1);
        check("t3_addr_8", imem_addr, 32'h8);
        nxt(); redirect = 1'b1; redirect_pc = 32'h40; smp();
        check("t3_req_redir", imem_req, 0);
        nxt(); redirect = 1'b0; smp();
        check("t3_req_wait", imem_req, 0);
        check("t3_valid_wait", inst_valid, 0);
        nxt(); smp();
        check("t3_req_new", imem_req, 1);
        check("t3_addr_new", imem_addr, 32'h40);
        check("t3_valid_stale", inst_valid, 0);
        for (int c = 0; c < 3; c++) begin
            nxt(); smp();
            check("t3_no_stale", inst_valid, 0);
        end
        nxt(); smp();
        check("t3_valid_40", inst_valid, 1);
        check("t3_pc_40", inst_pc, 32'h40);
        check("t3_inst_40", inst, 32'hDEAD_0040);

        // ---- redirect coinciding with rvalid, misaligned target ----
        do_reset(1'b0, 1);
        nxt(); smp();
        nxt(); redirect = 1'b1; redirect_pc = 32'h103; smp();
        check("t4_req_redir", imem_req, 0);
        check("t4_head_before", inst_pc, 32'h0);
        nxt(); redirect = 1'b0; smp();
        check("t4_empty", inst_valid, 0);
        check("t4_req", imem_req, 1);
        check("t4_addr", imem_addr, 32'h100);
        nxt(); smp();
        check("t4_valid_c4", inst_valid, 0);
        nxt(); smp();
        check("t4_valid_c5", inst_valid, 1);
        check("t4_pc_c5", inst_pc, 32'h100);
        check("t4_inst_c5", inst, 32'hDEAD_0100);

        // ---- async reset mid-flight, late rvalid ignored ----
        do_reset(1'b0, 3);
        for (int c = 1; c <= 9; c++) begin
            nxt(); smp();
        end
        check("t5_valid_pre", inst_valid, 1);
        check("t5_req_pre", imem_req, 1);
        check("t5_addr_pre", imem_addr, 32'hC);
        #1;
        rst = 1'b0;
        mem_gnt = 1'b0;
        #1;
        check("t5_valid_async", inst_valid, 0);
        check("t5_req_async", imem_req, 0);
        check("t5_pc_async", inst_pc, 32'h0);
        nxt(); smp();
        nxt(); smp();
        nxt(); rst = 1'b1; smp();
        check("t5_req_rel", imem_req, 1);
        check("t5_addr_rel", imem_addr, 32'h0);
        nxt(); mem_gnt = 1'b1; smp();
        check("t5_late_ignored", inst_valid, 0);
        check("t5_addr_restart", imem_addr, 32'h0);
        for (int c = 0; c < 3; c++) begin
            nxt(); smp();
            check("t5_empty", inst_valid, 0);
        end
        nxt(); smp();
        check("t5_valid_0", inst_valid, 1);
        check("t5_pc_0", inst_pc, 32'h0);
        check("t5_inst_0", inst, 32'hDEAD_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
